// File: rtl/exc_commit_ctrl_if.sv
// Pipeline-side bundle for the exception commit unit: MEM-stage sample, live CP0
// values, CP0 write port, stall, flush and redirect.
interface exc_commit_ctrl_if;
    logic        inst_valid_i;
    logic [4:0]  exc_flags_i;
    logic [31:0] inst_addr_i;
    logic        in_delayslot_i;
    logic [31:0] status_i;
    logic [31:0] cause_i;
    logic [31:0] epc_i;
    logic        cp0_we_o;
    logic [4:0]  cp0_waddr_o;
    logic [31:0] cp0_data_o;
    logic        busy_o;
    logic        flush_o;
    logic [31:0] new_pc_o;

    modport master (
        output inst_valid_i, exc_flags_i, inst_addr_i, in_delayslot_i,
               status_i, cause_i, epc_i,
        input  cp0_we_o, cp0_waddr_o, cp0_data_o, busy_o, flush_o, new_pc_o
    );

    modport slave (
        input  inst_valid_i, exc_flags_i, inst_addr_i, in_delayslot_i,
               status_i, cause_i, epc_i,
        output cp0_we_o, cp0_waddr_o, cp0_data_o, busy_o, flush_o, new_pc_o
    );
endinterface

// File: rtl/exc_commit_ctrl.sv
// Exception commit unit: prioritises the MEM-stage event, sequences EPC/Cause/Status
// writes over the single CP0 write port, then flushes and redirects the pipeline.
module exc_commit_ctrl #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_0020
) (
    input  logic            clk,
    input  logic            rst,
    exc_commit_ctrl_if.slave bus
);
    localparam int unsigned CODE_W = 5;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned XLEN   = 32;

    localparam logic [REG_W-1:0] REG_STATUS = REG_W'(12);
    localparam logic [REG_W-1:0] REG_CAUSE  = REG_W'(13);
    localparam logic [REG_W-1:0] REG_EPC    = REG_W'(14);

    typedef enum logic [2:0] {
        IDLE,
        W_EPC,
        W_CAUSE,
        W_STATUS,
        REDIRECT
    } state_t;

    state_t              state_q, state_d;
    logic [CODE_W-1:0]   code_q;
    logic                eret_q;
    logic [XLEN-1:0]     addr_q;
    logic                ds_q;
    logic                exl_q;

    logic                we_q;
    logic [REG_W-1:0]    waddr_q;
    logic [XLEN-1:0]     data_q;
    logic                busy_q;
    logic                flush_q;
    logic [XLEN-1:0]     new_pc_q;

    logic                intr_c;
    logic                det_evt_c;
    logic                det_eret_c;
    logic [CODE_W-1:0]   det_code_c;
    logic                take_c;

    logic [CODE_W-1:0]   e_code_c;
    logic                e_eret_c;
    logic [XLEN-1:0]     e_addr_c;
    logic                e_ds_c;
    logic                e_exl_c;

    logic [XLEN-1:0]     epc_w_c;
    logic [XLEN-1:0]     cause_w_c;
    logic [XLEN-1:0]     status_w_c;

    assign intr_c = (|(bus.cause_i[15:8] & bus.status_i[15:8]))
                    && !bus.status_i[1] && bus.status_i[0];

    // Fixed-priority event decode of the MEM-stage instruction
    always_comb begin
        det_evt_c  = 1'b1;
        det_eret_c = 1'b0;
        det_code_c = '0;
        if (intr_c)                   det_code_c = CODE_W'(0);
        else if (bus.exc_flags_i[0])  det_code_c = CODE_W'(8);
        else if (bus.exc_flags_i[1])  det_code_c = CODE_W'(10);
        else if (bus.exc_flags_i[2])  det_code_c = CODE_W'(13);
        else if (bus.exc_flags_i[3])  det_code_c = CODE_W'(12);
        else if (bus.exc_flags_i[4])  det_eret_c = 1'b1;
        else                          det_evt_c  = 1'b0;
    end

    assign take_c = (state_q == IDLE) && bus.inst_valid_i && det_evt_c;

    // On the detect edge the first write must use the fresh sample, not the latch
    assign e_code_c = take_c ? det_code_c         : code_q;
    assign e_eret_c = take_c ? det_eret_c         : eret_q;
    assign e_addr_c = take_c ? bus.inst_addr_i    : addr_q;
    assign e_ds_c   = take_c ? bus.in_delayslot_i : ds_q;
    assign e_exl_c  = take_c ? bus.status_i[1]    : exl_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (take_c) begin
                    if (det_eret_c)           state_d = W_STATUS;
                    else if (bus.status_i[1]) state_d = W_CAUSE;
                    else                      state_d = W_EPC;
                end
            end
            W_EPC:    state_d = W_CAUSE;
            W_CAUSE:  state_d = W_STATUS;
            W_STATUS: state_d = REDIRECT;
            REDIRECT: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Write payloads; nested exceptions keep the existing BD bit
    always_comb begin
        epc_w_c        = e_ds_c ? (e_addr_c - XLEN'(4)) : e_addr_c;
        cause_w_c      = bus.cause_i;
        cause_w_c[31]  = e_exl_c ? bus.cause_i[31] : e_ds_c;
        cause_w_c[6:2] = e_code_c;
        status_w_c     = bus.status_i;
        status_w_c[1]  = ~e_eret_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            code_q   <= '0;
            eret_q   <= 1'b0;
            addr_q   <= '0;
            ds_q     <= 1'b0;
            exl_q    <= 1'b0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            data_q   <= '0;
            busy_q   <= 1'b0;
            flush_q  <= 1'b0;
            new_pc_q <= '0;
        end else begin
            state_q <= state_d;
            if (take_c) begin
                code_q <= det_code_c;
                eret_q <= det_eret_c;
                addr_q <= bus.inst_addr_i;
                ds_q   <= bus.in_delayslot_i;
                exl_q  <= bus.status_i[1];
            end
            we_q    <= 1'b0;
            waddr_q <= '0;
            data_q  <= '0;
            busy_q  <= (state_d != IDLE);
            flush_q <= (state_d == REDIRECT);
            case (state_d)
                W_EPC: begin
                    we_q    <= 1'b1;
                    waddr_q <= REG_EPC;
                    data_q  <= epc_w_c;
                end
                W_CAUSE: begin
                    we_q    <= 1'b1;
                    waddr_q <= REG_CAUSE;
                    data_q  <= cause_w_c;
                end
                W_STATUS: begin
                    we_q    <= 1'b1;
                    waddr_q <= REG_STATUS;
                    data_q  <= status_w_c;
                end
                REDIRECT: new_pc_q <= e_eret_c ? bus.epc_i : HANDLER_ADDR;
                default: ;
            endcase
        end
    end

    assign bus.cp0_we_o    = we_q;
    assign bus.cp0_waddr_o = waddr_q;
    assign bus.cp0_data_o  = data_q;
    assign bus.busy_o      = busy_q;
    assign bus.flush_o     = flush_q;
    assign bus.new_pc_o    = new_pc_q;
endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Bench for exc_commit_ctrl: directed and randomized events checked cycle by cycle
// against a transaction-level model of the CP0 write/flush sequence.
module tb_exc_commit_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    exc_commit_ctrl_if bus();
    exc_commit_ctrl #(.HANDLER_ADDR(32'h0000_0020)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] d;
        logic        busy;
        logic        flush;
    } cyc_t;

    typedef struct {
        logic        v;
        logic [4:0]  f;
        logic [31:0] addr;
        logic        ds;
        logic [31:0] status;
        logic [31:0] cause;
        logic [31:0] epc;
    } txn_t;

    cyc_t        expq[$];
    logic [31:0] exp_pc = 32'h0;

    // Expected per-cycle port activity following one MEM-stage sample
    function automatic void build_model(input txn_t t);
        cyc_t        e;
        int          code;
        bit          eret;
        logic [31:0] c;
        expq.delete();
        code = -1;
        eret = 0;
        if (!t.v) return;
        if (((t.cause[15:8] & t.status[15:8]) != 8'h00) && !t.status[1] && t.status[0]) code = 0;
        else if (t.f[0]) code = 8;
        else if (t.f[1]) code = 10;
        else if (t.f[2]) code = 13;
        else if (t.f[3]) code = 12;
        else if (t.f[4]) eret = 1;
        else return;
        if (!eret && !t.status[1]) begin
            e = '{we: 1'b1, wa: 5'd14, d: (t.ds ? t.addr - 32'd4 : t.addr), busy: 1'b1, flush: 1'b0};
            expq.push_back(e);
        end
        if (!eret) begin
            c = t.cause;
            c[6:2] = 5'(code);
            if (!t.status[1]) c[31] = t.ds;
            e = '{we: 1'b1, wa: 5'd13, d: c, busy: 1'b1, flush: 1'b0};
            expq.push_back(e);
        end
        e = '{we: 1'b1, wa: 5'd12, d: (eret ? (t.status & ~32'h2) : (t.status | 32'h2)), busy: 1'b1, flush: 1'b0};
        expq.push_back(e);
        e = '{we: 1'b0, wa: 5'd0, d: 32'h0, busy: 1'b1, flush: 1'b1};
        expq.push_back(e);
        exp_pc = eret ? t.epc : 32'h0000_0020;
    endfunction

    function automatic cyc_t observe();
        cyc_t o;
        o.we    = bus.cp0_we_o;
        o.wa    = bus.cp0_waddr_o;
        o.d     = bus.cp0_data_o;
        o.busy  = bus.busy_o;
        o.flush = bus.flush_o;
        return o;
    endfunction

    function automatic txn_t mk(input logic v, input logic [4:0] f, input logic [31:0] addr,
                                input logic ds, input logic [31:0] status,
                                input logic [31:0] cause, input logic [31:0] epc);
        txn_t t;
        t.v = v; t.f = f; t.addr = addr; t.ds = ds;
        t.status = status; t.cause = cause; t.epc = epc;
        return t;
    endfunction

    task automatic test_reset();
        cyc_t o;
        rst = 1'b1;
        bus.inst_valid_i = 1'b0; bus.exc_flags_i = '0; bus.inst_addr_i = '0;
        bus.in_delayslot_i = 1'b0; bus.status_i = '0; bus.cause_i = '0; bus.epc_i = '0;
        repeat (3) @(negedge clk);
        o = observe();
        checks++;
        if (o !== cyc_t'(0) || bus.new_pc_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: got %h pc %h, want all zero", o, bus.new_pc_o);
        end
        rst = 1'b0;
        exp_pc = 32'h0;
    endtask

    task automatic test_directed();
        txn_t tab[$];
        cyc_t o;
        tab.push_back(mk(1, 5'b00001, 32'h0000_0100, 0, 32'h1000_0001, 32'h0000_0000, 32'h0));
        tab.push_back(mk(1, 5'b01000, 32'h0000_0204, 1, 32'h1000_0001, 32'h0000_0000, 32'h0));
        tab.push_back(mk(1, 5'b00001, 32'h0000_0300, 0, 32'h0000_0401, 32'h0000_0400, 32'h0));
        tab.push_back(mk(1, 5'b00000, 32'h0000_0310, 0, 32'h0000_0403, 32'h0000_0400, 32'h0));
        tab.push_back(mk(1, 5'b00001, 32'h0000_0320, 1, 32'h0000_0403, 32'h8000_0400, 32'h0));
        tab.push_back(mk(1, 5'b10000, 32'h0000_0400, 0, 32'h0000_0003, 32'h0000_0000, 32'h1234));
        tab.push_back(mk(0, 5'b00001, 32'h0000_0500, 0, 32'h1000_0001, 32'h0000_0000, 32'h0));
        tab.push_back(mk(1, 5'b01100, 32'h0000_0600, 0, 32'h1000_0001, 32'h0000_0000, 32'h0));
        tab.push_back(mk(1, 5'b10110, 32'h0000_0000, 1, 32'h0000_0001, 32'hffff_00ff, 32'h0));
        foreach (tab[k]) begin
            bus.inst_valid_i = tab[k].v; bus.exc_flags_i = tab[k].f;
            bus.inst_addr_i = tab[k].addr; bus.in_delayslot_i = tab[k].ds;
            bus.status_i = tab[k].status; bus.cause_i = tab[k].cause; bus.epc_i = tab[k].epc;
            build_model(tab[k]);
            @(posedge clk); #1;
            bus.inst_valid_i = 1'b0;
            for (int i = 0; i < expq.size(); i++) begin
                @(negedge clk);
                o = observe();
                checks++;
                if (o !== expq[i]) begin
                    errors++;
                    $display("FAIL dir%0d_cyc%0d: got %h, want %h", k, i, o, expq[i]);
                end
                if (expq[i].flush) begin
                    checks++;
                    if (bus.new_pc_o !== exp_pc) begin
                        errors++;
                        $display("FAIL dir%0d_new_pc: got %h, want %h", k, bus.new_pc_o, exp_pc);
                    end
                end
            end
            @(negedge clk);
            o = observe();
            checks++;
            if (o !== cyc_t'(0) || bus.new_pc_o !== exp_pc) begin
                errors++;
                $display("FAIL dir%0d_idle: got %h pc %h, want 0 pc %h", k, o, bus.new_pc_o, exp_pc);
            end
        end
    endtask

    // Back-to-back random events; junk on the MEM-stage inputs while busy must be ignored
    task automatic test_random();
        txn_t t;
        cyc_t o;
        for (int k = 0; k < 80; k++) begin
            t.v      = ($urandom % 4) != 0;
            t.f      = (($urandom % 5) == 0) ? 5'h0 : 5'($urandom);
            t.addr   = $urandom;
            t.ds     = 1'($urandom);
            t.status = $urandom;
            t.cause  = $urandom;
            t.epc    = $urandom;
            bus.inst_valid_i = t.v; bus.exc_flags_i = t.f;
            bus.inst_addr_i = t.addr; bus.in_delayslot_i = t.ds;
            bus.status_i = t.status; bus.cause_i = t.cause; bus.epc_i = t.epc;
            build_model(t);
            @(posedge clk); #1;
            if (expq.size() > 0) begin
                bus.inst_valid_i = 1'($urandom); bus.exc_flags_i = 5'($urandom);
                bus.inst_addr_i = $urandom; bus.in_delayslot_i = 1'($urandom);
            end else begin
                bus.inst_valid_i = 1'b0;
            end
            for (int i = 0; i < expq.size(); i++) begin
                @(negedge clk);
                o = observe();
                checks++;
                if (o !== expq[i]) begin
                    errors++;
                    $display("FAIL rnd%0d_cyc%0d: got %h, want %h", k, i, o, expq[i]);
                end
                if (expq[i].flush) begin
                    checks++;
                    if (bus.new_pc_o !== exp_pc) begin
                        errors++;
                        $display("FAIL rnd%0d_new_pc: got %h, want %h", k, bus.new_pc_o, exp_pc);
                    end
                    bus.inst_valid_i = 1'b0;
                end
            end
            @(negedge clk);
            o = observe();
            checks++;
            if (o !== cyc_t'(0) || bus.new_pc_o !== exp_pc) begin
                errors++;
                $display("FAIL rnd%0d_idle: got %h pc %h, want 0 pc %h", k, o, bus.new_pc_o, exp_pc);
            end
        end
    endtask

    task automatic test_reset_mid();
        cyc_t o;
        bus.inst_valid_i = 1'b1; bus.exc_flags_i = 5'b00001;
        bus.inst_addr_i = 32'h0000_0700; bus.in_delayslot_i = 1'b0;
        bus.status_i = 32'h1000_0001; bus.cause_i = 32'h0; bus.epc_i = 32'h0;
        @(posedge clk); #1;
        bus.inst_valid_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.cp0_we_o !== 1'b1 || bus.cp0_waddr_o !== 5'd13) begin
            errors++;
            $display("FAIL rstmid_in_cause: got we %b wa %0d, want we 1 wa 13", bus.cp0_we_o, bus.cp0_waddr_o);
        end
        rst = 1'b1;
        @(negedge clk);
        o = observe();
        checks++;
        if (o !== cyc_t'(0) || bus.new_pc_o !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_clear: got %h pc %h, want all zero", o, bus.new_pc_o);
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            o = observe();
            checks++;
            if (o !== cyc_t'(0)) begin
                errors++;
                $display("FAIL rstmid_quiet%0d: got %h, want 0", i, o);
            end
        end
        exp_pc = 32'h0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
